// File: rtl/scan_pkg.sv
// Shared types and constants for the sequence-detector scan sequencer.
// Holds the FSM state encoding, default sizes and a count-width helper.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  // Smallest count width whose range strictly exceeds the word width.
  function automatic int min_cnt_w(input int width);
    int w;
    w = 1;
    while ((1 << w) <= width) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/scan_shifter.sv
// Loadable shift register presenting the next bit to scan on head.
// Bit order: MSB first by default, LSB first when SCAN_LSB_FIRST_EN is defined.
module scan_shifter
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             head
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (shift) begin
`ifdef SCAN_LSB_FIRST_EN
      q <= {1'b0, q[WIDTH-1:1]};
`else
      q <= {q[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef SCAN_LSB_FIRST_EN
  assign head = q[0];
`else
  assign head = q[WIDTH-1];
`endif

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serializes a word into the Moore detector and counts its output highs; accept-to-done WIDTH+3 cycles.
// start is honoured only while ready; starts during a scan are dropped. Bit order via SCAN_LSB_FIRST_EN.
module seq_scan_ctrl
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             fsm_rst_n,
  output logic             fsm_in,
  input  logic             fsm_out,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] bit_idx;
  logic             accept;
  logic             last_bit;
  logic             sample_en;
  logic             shift_en;
  logic             head;

  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));

  scan_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (shift_en),
    .data_in (data_in),
    .head    (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    sample_en  = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = CLEAR;
        end
      end
      CLEAR: next_state = SHIFT;
      SHIFT: begin
        // The detector output lags its input by one cycle, so the first SHIFT cycle has nothing to sample yet.
        sample_en = (bit_idx != '0);
        if (last_bit) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        sample_en  = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    busy     = ~ready;
    shift_en = (next_state == SHIFT);
  end

  // Detector-facing outputs are decoded from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_in    <= 1'b0;
      fsm_rst_n <= 1'b0;
    end else begin
      fsm_in    <= shift_en ? head : 1'b0;
      fsm_rst_n <= (next_state != CLEAR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (accept) begin
      bit_idx <= '0;
    end else if (state == SHIFT && !last_bit) begin
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (sample_en && fsm_out) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
